// File: rtl/multicycle_ctrl.sv
// Sequencing FSM for the 64-bit LEGv8 multicycle datapath: register enables,
// mux selects, ALU op, and the shared memory port handshake with a timeout.
module multicycle_ctrl #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [10:0] op,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        pc_we,
    output logic        ir_we,
    output logic        reg_we,
    output logic        mem_read,
    output logic        mem_write,
    output logic        pc_src,
    output logic        alu_src,
    output logic        reg2loc,
    output logic        mem_to_reg,
    output logic [1:0]  alu_op,
    output logic [2:0]  state,
    output logic        retire,
    output logic        halted
);

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_HALT   = 3'd7;

    localparam logic [1:0] ALU_ADD  = 2'b00;
    localparam logic [1:0] ALU_PASS = 2'b01;
    localparam logic [1:0] ALU_FUNC = 2'b10;

    localparam int CW = $clog2(TIMEOUT);

    typedef struct packed {
        logic       pc_we;
        logic       ir_we;
        logic       reg_we;
        logic       mem_read;
        logic       mem_write;
        logic       pc_src;
        logic       alu_src;
        logic       reg2loc;
        logic       mem_to_reg;
        logic [1:0] alu_op;
        logic       retire;
        logic       halted;
    } ctrl_t;

    typedef struct packed {
        logic r;
        logic ldur;
        logic stur;
        logic cbz;
        logic b;
    } iclass_t;

    logic [2:0]    state_q, state_nxt;
    logic [CW-1:0] cnt_q;
    logic          waiting;
    logic          expired;
    iclass_t       ic;
    logic          legal;
    ctrl_t         c;

    always_comb begin
        ic.r    = (op == 11'b10001011000) || (op == 11'b11001011000) ||
                  (op == 11'b10001010000) || (op == 11'b10101010000);
        ic.ldur = (op == 11'b11111000010);
        ic.stur = (op == 11'b11111000000);
        ic.cbz  = (op[10:3] == 8'b10110100);
        ic.b    = (op[10:5] == 6'b000101);
        legal   = |ic;
    end

    // A request is outstanding in FETCH, and in MEM for a memory instruction.
    assign waiting = (state_q == S_FETCH) ||
                     ((state_q == S_MEM) && (ic.ldur || ic.stur));
    assign expired = (cnt_q == CW'(TIMEOUT - 1));

    always_comb begin
        c         = '0;
        state_nxt = state_q;
        case (state_q)
            S_FETCH: begin
                c.mem_read = 1'b1;
                if (mem_ready) begin
                    c.ir_we   = 1'b1;
                    c.pc_we   = 1'b1;
                    state_nxt = S_DECODE;
                end else if (expired) begin
                    state_nxt = S_HALT;
                end
            end
            S_DECODE: begin
                c.reg2loc = ic.stur || ic.cbz;
                state_nxt = legal ? S_EXEC : S_HALT;
            end
            S_EXEC: begin
                if (ic.r) begin
                    c.alu_op  = ALU_FUNC;
                    state_nxt = S_WB;
                end else if (ic.ldur || ic.stur) begin
                    c.alu_src = 1'b1;
                    c.alu_op  = ALU_ADD;
                    c.reg2loc = ic.stur;
                    state_nxt = S_MEM;
                end else if (ic.cbz) begin
                    c.reg2loc = 1'b1;
                    c.alu_op  = ALU_PASS;
                    c.retire  = 1'b1;
                    c.pc_we   = zero;
                    c.pc_src  = zero;
                    state_nxt = S_FETCH;
                end else if (ic.b) begin
                    c.pc_we   = 1'b1;
                    c.pc_src  = 1'b1;
                    c.retire  = 1'b1;
                    state_nxt = S_FETCH;
                end else begin
                    state_nxt = S_HALT;
                end
            end
            S_MEM: begin
                if (ic.ldur) begin
                    c.mem_read = 1'b1;
                    c.alu_src  = 1'b1;
                    if (mem_ready)    state_nxt = S_WB;
                    else if (expired) state_nxt = S_HALT;
                end else if (ic.stur) begin
                    c.mem_write = 1'b1;
                    c.alu_src   = 1'b1;
                    c.reg2loc   = 1'b1;
                    if (mem_ready) begin
                        c.retire  = 1'b1;
                        state_nxt = S_FETCH;
                    end else if (expired) begin
                        state_nxt = S_HALT;
                    end
                end else begin
                    state_nxt = S_HALT;
                end
            end
            S_WB: begin
                c.reg_we     = 1'b1;
                c.retire     = 1'b1;
                c.mem_to_reg = ic.ldur;
                state_nxt    = S_FETCH;
            end
            S_HALT: begin
                c.halted  = 1'b1;
                state_nxt = S_HALT;
            end
            default: state_nxt = S_HALT;
        endcase
        // Reset overrides every strobe combinationally, not just at the next edge.
        if (reset) c = '0;
    end

    // Counter is zero outside a wait, so entry to FETCH/MEM always starts clean.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
            cnt_q   <= '0;
        end else begin
            state_q <= state_nxt;
            cnt_q   <= (waiting && !mem_ready) ? cnt_q + CW'(1) : '0;
        end
    end

    assign pc_we      = c.pc_we;
    assign ir_we      = c.ir_we;
    assign reg_we     = c.reg_we;
    assign mem_read   = c.mem_read;
    assign mem_write  = c.mem_write;
    assign pc_src     = c.pc_src;
    assign alu_src    = c.alu_src;
    assign reg2loc    = c.reg2loc;
    assign mem_to_reg = c.mem_to_reg;
    assign alu_op     = c.alu_op;
    assign retire     = c.retire;
    assign halted     = c.halted;
    assign state      = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: the driver queues a hand-computed output
// vector per driven cycle, the monitor pops and compares it mid-cycle.
module tb_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [10:0] op = '0;
    logic        zero = 1'b0;
    logic        mem_ready = 1'b0;
    logic        pc_we, ir_we, reg_we, mem_read, mem_write, pc_src;
    logic        alu_src, reg2loc, mem_to_reg, retire, halted;
    logic [1:0]  alu_op;
    logic [2:0]  state;

    multicycle_ctrl #(.TIMEOUT(16)) dut (
        .clk(clk), .reset(reset), .op(op), .zero(zero), .mem_ready(mem_ready),
        .pc_we(pc_we), .ir_we(ir_we), .reg_we(reg_we), .mem_read(mem_read),
        .mem_write(mem_write), .pc_src(pc_src), .alu_src(alu_src),
        .reg2loc(reg2loc), .mem_to_reg(mem_to_reg), .alu_op(alu_op),
        .state(state), .retire(retire), .halted(halted)
    );

    always #5 clk = ~clk;

    // Strobe bits of the 13-bit field below the 3-bit state.
    localparam logic [12:0] PCW = 13'h1000, IRW = 13'h0800, RGW = 13'h0400;
    localparam logic [12:0] MR  = 13'h0200, MW  = 13'h0100, PCS = 13'h0080;
    localparam logic [12:0] ALS = 13'h0040, R2L = 13'h0020, M2R = 13'h0010;
    localparam logic [12:0] AFN = 13'h0008, APS = 13'h0004, RET = 13'h0002;
    localparam logic [12:0] HLT = 13'h0001, NONE = 13'h0000;

    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;
    localparam logic [10:0] OP_CBZ  = 11'b10110100101;
    localparam logic [10:0] OP_B    = 11'b00010100000;
    localparam logic [10:0] OP_BAD  = 11'b00000000000;

    logic [15:0] exp_q[$];
    string       nm_q[$];
    int          n_chk = 0;
    int          n_fail = 0;

    function automatic logic [15:0] ev(input logic [2:0] st, input logic [12:0] s);
        return {st, s};
    endfunction

    wire [15:0] act = {state, pc_we, ir_we, reg_we, mem_read, mem_write, pc_src,
                       alu_src, reg2loc, mem_to_reg, alu_op, retire, halted};

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [15:0] e;
            string       n;
            e = exp_q.pop_front();
            n = nm_q.pop_front();
            n_chk++;
            if (act !== e) begin
                n_fail++;
                $display("FAIL %s: got state=%0d strobes=%013b, expected state=%0d strobes=%013b",
                         n, act[15:13], act[12:0], e[15:13], e[12:0]);
            end
        end
    end

    task automatic step(input string nm, input logic r, input logic [10:0] o,
                        input logic z, input logic m, input logic [15:0] e);
        @(posedge clk);
        #1;
        reset = r; op = o; zero = z; mem_ready = m;
        exp_q.push_back(e);
        nm_q.push_back(nm);
    endtask

    task automatic fetch_ok(input string nm, input logic [10:0] o);
        step({nm, "_fetch"}, 1'b0, o, 1'b0, 1'b1, ev(3'd0, MR | IRW | PCW));
    endtask

    initial begin
        step("reset", 1'b1, OP_ADD, 1'b0, 1'b1, ev(3'd0, NONE));

        // ADD, no waits: 0,1,2,4
        fetch_ok("add", OP_ADD);
        step("add_decode", 1'b0, OP_ADD, 1'b0, 1'b1, ev(3'd1, NONE));
        step("add_exec",   1'b0, OP_ADD, 1'b0, 1'b1, ev(3'd2, AFN));
        step("add_wb",     1'b0, OP_ADD, 1'b0, 1'b1, ev(3'd4, RGW | RET));

        // LDUR with three wait cycles in MEM: 8 cycles total
        fetch_ok("ldur", OP_LDUR);
        step("ldur_decode", 1'b0, OP_LDUR, 1'b0, 1'b1, ev(3'd1, NONE));
        step("ldur_exec",   1'b0, OP_LDUR, 1'b0, 1'b0, ev(3'd2, ALS));
        for (int i = 0; i < 3; i++)
            step("ldur_mem_wait", 1'b0, OP_LDUR, 1'b0, 1'b0, ev(3'd3, MR | ALS));
        step("ldur_mem_done", 1'b0, OP_LDUR, 1'b0, 1'b1, ev(3'd3, MR | ALS));
        step("ldur_wb",       1'b0, OP_LDUR, 1'b0, 1'b1, ev(3'd4, RGW | RET | M2R));

        // CBZ taken, then not taken
        fetch_ok("cbz1", OP_CBZ);
        step("cbz1_decode", 1'b0, OP_CBZ, 1'b1, 1'b1, ev(3'd1, R2L));
        step("cbz1_exec",   1'b0, OP_CBZ, 1'b1, 1'b1, ev(3'd2, R2L | APS | RET | PCW | PCS));
        fetch_ok("cbz0", OP_CBZ);
        step("cbz0_decode", 1'b0, OP_CBZ, 1'b0, 1'b1, ev(3'd1, R2L));
        step("cbz0_exec",   1'b0, OP_CBZ, 1'b0, 1'b1, ev(3'd2, R2L | APS | RET));

        // B
        fetch_ok("b", OP_B);
        step("b_decode", 1'b0, OP_B, 1'b0, 1'b1, ev(3'd1, NONE));
        step("b_exec",   1'b0, OP_B, 1'b0, 1'b1, ev(3'd2, PCW | PCS | RET));

        // STUR, no waits: 4 cycles
        fetch_ok("stur", OP_STUR);
        step("stur_decode", 1'b0, OP_STUR, 1'b0, 1'b1, ev(3'd1, R2L));
        step("stur_exec",   1'b0, OP_STUR, 1'b0, 1'b1, ev(3'd2, ALS | R2L));
        step("stur_mem",    1'b0, OP_STUR, 1'b0, 1'b1, ev(3'd3, MW | ALS | R2L | RET));

        // Illegal op halts; HALT is sticky regardless of inputs
        fetch_ok("bad", OP_BAD);
        step("bad_decode", 1'b0, OP_BAD, 1'b0, 1'b1, ev(3'd1, NONE));
        for (int i = 0; i < 20; i++)
            step("halt_sticky", 1'b0, (i % 2 == 0) ? OP_ADD : OP_BAD, i[0], i[1],
                 ev(3'd7, HLT));
        step("halt_reset", 1'b1, OP_ADD, 1'b0, 1'b1, ev(3'd0, NONE));
        fetch_ok("after_halt", OP_ADD);
        step("after_halt_decode", 1'b0, OP_ADD, 1'b0, 1'b1, ev(3'd1, NONE));
        step("after_halt_exec",   1'b0, OP_ADD, 1'b0, 1'b1, ev(3'd2, AFN));
        step("after_halt_wb",     1'b0, OP_ADD, 1'b0, 1'b1, ev(3'd4, RGW | RET));

        // FETCH timeout: 16 low cycles, HALT on the 16th edge
        for (int i = 0; i < 16; i++)
            step("fetch_wait", 1'b0, OP_ADD, 1'b0, 1'b0, ev(3'd0, MR));
        step("fetch_timeout", 1'b0, OP_ADD, 1'b0, 1'b0, ev(3'd7, HLT));
        step("to_reset", 1'b1, OP_ADD, 1'b0, 1'b0, ev(3'd0, NONE));

        // Same, but mem_ready arrives on the 16th cycle and wins
        for (int i = 0; i < 15; i++)
            step("fetch_wait2", 1'b0, OP_ADD, 1'b0, 1'b0, ev(3'd0, MR));
        step("fetch_last_ready", 1'b0, OP_ADD, 1'b0, 1'b1, ev(3'd0, MR | IRW | PCW));
        step("fetch_last_decode", 1'b0, OP_ADD, 1'b0, 1'b1, ev(3'd1, NONE));
        step("fetch_last_exec",   1'b0, OP_ADD, 1'b0, 1'b1, ev(3'd2, AFN));
        step("fetch_last_wb",     1'b0, OP_ADD, 1'b0, 1'b1, ev(3'd4, RGW | RET));

        // MEM timeout during LDUR
        fetch_ok("ldto", OP_LDUR);
        step("ldto_decode", 1'b0, OP_LDUR, 1'b0, 1'b0, ev(3'd1, NONE));
        step("ldto_exec",   1'b0, OP_LDUR, 1'b0, 1'b0, ev(3'd2, ALS));
        for (int i = 0; i < 16; i++)
            step("ldto_mem_wait", 1'b0, OP_LDUR, 1'b0, 1'b0, ev(3'd3, MR | ALS));
        step("ldto_halt", 1'b0, OP_LDUR, 1'b0, 1'b0, ev(3'd7, HLT));
        step("ldto_reset", 1'b1, OP_STUR, 1'b0, 1'b1, ev(3'd0, NONE));

        // Reset asserted mid-cycle during a STUR wait, then a normal STUR
        fetch_ok("stw", OP_STUR);
        step("stw_decode", 1'b0, OP_STUR, 1'b0, 1'b0, ev(3'd1, R2L));
        step("stw_exec",   1'b0, OP_STUR, 1'b0, 1'b0, ev(3'd2, ALS | R2L));
        step("stw_mem_wait", 1'b0, OP_STUR, 1'b0, 1'b0, ev(3'd3, MW | ALS | R2L));
        step("stw_mem_wait", 1'b0, OP_STUR, 1'b0, 1'b0, ev(3'd3, MW | ALS | R2L));
        step("stw_reset",  1'b1, OP_STUR, 1'b0, 1'b1, ev(3'd0, NONE));
        fetch_ok("stn", OP_STUR);
        step("stn_decode", 1'b0, OP_STUR, 1'b0, 1'b1, ev(3'd1, R2L));
        step("stn_exec",   1'b0, OP_STUR, 1'b0, 1'b1, ev(3'd2, ALS | R2L));
        step("stn_mem",    1'b0, OP_STUR, 1'b0, 1'b1, ev(3'd3, MW | ALS | R2L | RET));
        step("stn_next",   1'b0, OP_STUR, 1'b0, 1'b0, ev(3'd0, MR));

        // Drain the scoreboard within a bounded number of cycles
        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge clk);
        if (exp_q.size() > 0) begin
            n_fail++;
            $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

- Sequencing FSM for the 64-bit LEGv8 multicycle datapath.
- Produces the register-enable strobes for the datapath's `flopr`-style state registers (PC, IR, fetched-PC) and for the register file and memory.
- Selects the datapath muxes and the ALU operation.
- Handles the shared memory port's variable-latency `mem_ready` handshake, with a timeout.

## Interface
- `TIMEOUT`, default 16: consecutive `mem_ready`-low cycles allowed in one wait state before the FSM halts (must be ≥2).
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high.
- `op` in 11: `IR[31:21]`, valid from the DECODE state onward.
- `zero` in 1: ALU zero flag, valid in EXEC.
- `mem_ready` in 1: memory has completed the current read or write this cycle.
- `pc_we` out 1: PC register enable.
- `ir_we` out 1: enable for the IR and fetched-PC registers.
- `reg_we` out 1: register file write enable.
- `mem_read` out 1: memory read request.
- `mem_write` out 1: memory write request.
- `pc_src` out 1: 0 selects PC+4; 1 selects fetched-PC + offset.
- `alu_src` out 1: 0 selects reg B; 1 selects the sign-extended immediate.
- `reg2loc` out 1: 1 selects `IR[4:0]` as read register 2.
- `mem_to_reg` out 1: 1 selects memory data as write-back data.
- `alu_op` out 2: 00 add, 01 pass B, 10 R-type function.
- `state` out 3: current state encoding.
- `retire` out 1: one-cycle pulse on the final cycle of each instruction.
- `halted` out 1: high while in HALT.

## Operation
- **State encoding:** FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=7. Codes 5 and 6 are unused and go to HALT on the next edge.
- **Instruction classes**, decoded from `op`:
  - R: ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000.
  - LDUR: 11111000010.
  - STUR: 11111000000.
  - CBZ: `op[10:3]` = 10110100.
  - B: `op[10:5]` = 000101.
  - Anything else is illegal.
- **Output decode:** all outputs are decoded from `state`, `op`, `zero` and `mem_ready`. Any strobe not listed below is 0.
- **FETCH:**
  - `mem_read`=1.
  - When `mem_ready`=1: `ir_we`=1, `pc_we`=1, `pc_src`=0, then go to DECODE. Otherwise stay in FETCH.
- **DECODE:**
  - `reg2loc`=1 for STUR and CBZ.
  - Legal op: go to EXEC. Illegal op: go to HALT.
- **EXEC:**
  - R: `alu_op`=10, then WB.
  - LDUR/STUR: `alu_src`=1, `alu_op`=00, `reg2loc` follows the DECODE rule, then MEM.
  - CBZ: `reg2loc`=1, `alu_op`=01, `retire`=1. If `zero`=1, also `pc_we`=1 and `pc_src`=1. Then FETCH.
  - B: `pc_we`=1, `pc_src`=1, `retire`=1, then FETCH.
- **MEM:**
  - LDUR: `mem_read`=1, `alu_src`=1. On `mem_ready`, go to WB.
  - STUR: `mem_write`=1, `alu_src`=1, `reg2loc`=1. On `mem_ready`, assert `retire`=1 and go to FETCH.
- **WB:**
  - `reg_we`=1 and `retire`=1.
  - `mem_to_reg`=1 for LDUR, 0 for R-type.
  - Then FETCH.
- **HALT:**
  - All strobes 0, `halted`=1.
  - Sticky; only `reset` leaves HALT.
- **Timeout counter** (width `$clog2(TIMEOUT)`):
  - Cleared on entry to FETCH or MEM.
  - Increments every cycle in which a request is outstanding and `mem_ready`=0.
  - If `mem_ready`=0 while count == TIMEOUT−1, the next state is HALT.
  - `mem_ready`=1 on that same cycle wins: normal transition.
- **Reset behaviour:**
  - `reset` high: `state`=FETCH and counter=0 immediately, without waiting for a clock edge.
  - While `reset` is high, all outputs are forced to 0, including `mem_read`.
  - FETCH begins on the first rising edge after `reset` is released.

## Timing
- **Minimum cycles per instruction** with `mem_ready` tied to 1: R=4, LDUR=5, STUR=4, CBZ=3, B=3.
- **Memory waits:** each extra low cycle of `mem_ready` in FETCH or MEM adds one cycle.
- **Strobe timing:** `pc_we`, `ir_we` and `reg_we` take effect on the edge that ends the cycle in which they are asserted. Branch targets use the fetched-PC register latched with the IR, never the incremented PC.
- **Request hold:** `mem_read` and `mem_write` are level-held for the whole wait and drop in the cycle after `mem_ready`.
- **`retire`:** exactly one cycle per completed instruction. Never asserted in HALT or in DECODE.
- **Reset mid-operation** (for example in MEM during a STUR): `mem_write` falls in the same cycle as `reset` rises. No `retire` pulse occurs.

## Test plan
- **ADD (op 10001011000), `mem_ready`=1:** `state` sequence 0,1,2,4,0. `reg_we`=1 and `retire`=1 only in state 4. `alu_op`=10 in state 2.
- **LDUR with `mem_ready` low for 3 cycles in MEM:** state 3 is held for 4 cycles with `mem_read`=1. WB shows `mem_to_reg`=1 and `reg_we`=1. Total of 8 cycles.
- **CBZ (op 10110100xxx):**
  - `zero`=1: `pc_we`=1 and `pc_src`=1 in EXEC.
  - `zero`=0: `pc_we`=0.
  - Both cases return to FETCH after 3 cycles with one `retire` pulse.
- **Illegal op 00000000000:** DECODE→HALT. `halted`=1 and all strobes 0 for 20 cycles. After `reset`, FETCH resumes with `mem_read`=1.
- **Timeout, `TIMEOUT`=16, `mem_ready`=0 in FETCH:**
  - HALT is entered on the 16th edge.
  - A repeat run with `mem_ready`=1 on the 16th cycle goes to DECODE instead.
- **Reset asserted mid-STUR wait in MEM:** `state`=0 and `mem_write`=0 in the same cycle, with no `retire`. A normal fetch follows the release of `reset`.
